// File: rtl/ascon_block_feeder_pkg.sv
// Shared types and constants for the ASCON block feeder and its padding helper.
package ascon_cfg;

   localparam int         RATE_BYTES_DEF = 8;
   localparam logic [7:0] PAD_BYTE       = 8'h80;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      EMIT,
      PAD
   } feeder_state_e;

   typedef enum logic {
      SEG_AD,
      SEG_TEXT
   } seg_e;

endpackage

// File: rtl/ascon_block_feeder_if.sv
// Word-stream input and block output bundle of the feeder; master is the feeder side.
interface ascon_block_feeder_if #(
   parameter int RATE_BYTES = 8
) ();

   logic                    in_valid_i;
   logic                    in_ready_o;
   logic [31:0]             in_data_i;
   logic                    in_last_i;
   logic [2:0]              in_bytes_i;
   logic                    blk_valid_o;
   logic                    blk_ready_i;
   logic [RATE_BYTES*8-1:0] blk_data_o;
   logic                    blk_is_text_o;
   logic                    blk_last_o;

   modport master (
      input  in_valid_i, in_data_i, in_last_i, in_bytes_i, blk_ready_i,
      output in_ready_o, blk_valid_o, blk_data_o, blk_is_text_o, blk_last_o
   );

   modport slave (
      output in_valid_i, in_data_i, in_last_i, in_bytes_i, blk_ready_i,
      input  in_ready_o, blk_valid_o, blk_data_o, blk_is_text_o, blk_last_o
   );

endinterface

// File: rtl/ascon_pad_gen.sv
// ASCON 10* padding: keeps bytes below off_i, puts 0x80 at off_i, zeroes the rest.
module ascon_pad_gen
   import ascon_cfg::*;
#(
   parameter int RATE_BYTES = RATE_BYTES_DEF
) (
   input  logic [$clog2(RATE_BYTES+1)-1:0] off_i,
   input  logic [RATE_BYTES*8-1:0]         data_i,
   output logic [RATE_BYTES*8-1:0]         data_o
);

   localparam int CW = $clog2(RATE_BYTES + 1);

   genvar gi;
   generate
      for (gi = 0; gi < RATE_BYTES; gi++) begin : g_byte
         localparam logic [CW-1:0] IDX = CW'(gi);
         assign data_o[RATE_BYTES*8-1-8*gi -: 8] =
            (IDX < off_i)  ? data_i[RATE_BYTES*8-1-8*gi -: 8] :
            (IDX == off_i) ? PAD_BYTE : 8'h00;
      end
   endgenerate

endmodule

// File: rtl/ascon_block_feeder.sv
// Packs AD/text words into padded rate blocks for the ASCON core.
// Optional blk_bytes_o message-byte count: define ASCON_BLOCK_BYTE_CNT_EN.
module ascon_block_feeder
   import ascon_cfg::*;
#(
   parameter int RATE_BYTES = RATE_BYTES_DEF
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 start_i,
   input  logic                 ad_empty_i,
   input  logic                 text_empty_i,
   ascon_block_feeder_if.master bus_if,
`ifdef ASCON_BLOCK_BYTE_CNT_EN
   output logic [$clog2(RATE_BYTES+1)-1:0] blk_bytes_o,
`endif
   output logic                 last_ad_block_o,
   output logic                 last_text_block_o,
   output logic                 busy_o,
   output logic                 done_o
);

   localparam int                      CW      = $clog2(RATE_BYTES + 1);
   localparam int                      BW      = RATE_BYTES * 8;
   localparam logic [CW-1:0]           FULL    = CW'(RATE_BYTES);
   localparam logic [BW-1:0]           PAD_BLK = {PAD_BYTE, {(BW-8){1'b0}}};

   feeder_state_e state_q, state_d;
   seg_e          seg_q, seg_d;
   logic          text_empty_q, text_empty_d;
   logic          pend_pad_q, pend_pad_d;
   logic          last_q, last_d;
   logic          done_q, done_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [BW-1:0] pack_q, pack_d;
   logic [CW-1:0] cnt_add, cnt_next;
   logic [BW-1:0] wr_blk, pad_blk;
   logic          pulse_ad, pulse_text;
`ifdef ASCON_BLOCK_BYTE_CNT_EN
   logic [CW-1:0] bytes_q, bytes_d;
`endif

   assign cnt_add  = bus_if.in_last_i ? CW'(bus_if.in_bytes_i) : CW'(4);
   assign cnt_next = cnt_q + cnt_add;

   // cnt_q is always word aligned, so each word slot is selected by an exact offset match.
   genvar gi;
   generate
      for (gi = 0; gi < RATE_BYTES / 4; gi++) begin : g_word
         assign wr_blk[BW-1-32*gi -: 32] = (cnt_q == CW'(4*gi)) ? bus_if.in_data_i
                                                               : pack_q[BW-1-32*gi -: 32];
      end
   endgenerate

   ascon_pad_gen #(.RATE_BYTES(RATE_BYTES)) u_pad_gen (
      .off_i  (cnt_next),
      .data_i (wr_blk),
      .data_o (pad_blk)
   );

   always_comb begin
      state_d      = state_q;
      seg_d        = seg_q;
      text_empty_d = text_empty_q;
      pend_pad_d   = pend_pad_q;
      last_d       = last_q;
      done_d       = 1'b0;
      cnt_d        = cnt_q;
      pack_d       = pack_q;
      pulse_ad     = 1'b0;
      pulse_text   = 1'b0;
`ifdef ASCON_BLOCK_BYTE_CNT_EN
      bytes_d      = bytes_q;
`endif
      case (state_q)
         IDLE: begin
            if (start_i) begin
               seg_d        = ad_empty_i ? SEG_TEXT : SEG_AD;
               text_empty_d = text_empty_i;
               pend_pad_d   = 1'b0;
               cnt_d        = '0;
               state_d      = (ad_empty_i && text_empty_i) ? PAD : COLLECT;
            end
         end
         COLLECT: begin
            if (bus_if.in_valid_i) begin
               cnt_d  = cnt_next;
               pack_d = pad_blk;
               if (bus_if.in_last_i || cnt_next == FULL) begin
                  state_d    = EMIT;
                  last_d     = bus_if.in_last_i && (cnt_next != FULL);
                  pend_pad_d = bus_if.in_last_i && (cnt_next == FULL);
`ifdef ASCON_BLOCK_BYTE_CNT_EN
                  bytes_d    = cnt_next;
`endif
               end
            end
         end
         EMIT, PAD: begin
            if (bus_if.blk_ready_i) begin
               cnt_d = '0;
               if (state_q == EMIT && pend_pad_q) begin
                  pend_pad_d = 1'b0;
                  state_d    = PAD;
               end else if (state_q == EMIT && !last_q) begin
                  state_d = COLLECT;
               end else if (seg_q == SEG_AD) begin
                  pulse_ad = 1'b1;
                  seg_d    = SEG_TEXT;
                  state_d  = text_empty_q ? PAD : COLLECT;
               end else begin
                  pulse_text = 1'b1;
                  done_d     = 1'b1;
                  state_d    = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= IDLE;
         seg_q        <= SEG_AD;
         text_empty_q <= 1'b0;
         pend_pad_q   <= 1'b0;
         last_q       <= 1'b0;
         done_q       <= 1'b0;
         cnt_q        <= '0;
         pack_q       <= '0;
`ifdef ASCON_BLOCK_BYTE_CNT_EN
         bytes_q      <= '0;
`endif
      end else begin
         state_q      <= state_d;
         seg_q        <= seg_d;
         text_empty_q <= text_empty_d;
         pend_pad_q   <= pend_pad_d;
         last_q       <= last_d;
         done_q       <= done_d;
         cnt_q        <= cnt_d;
         pack_q       <= pack_d;
`ifdef ASCON_BLOCK_BYTE_CNT_EN
         bytes_q      <= bytes_d;
`endif
      end
   end

   assign bus_if.in_ready_o    = (state_q == COLLECT);
   assign bus_if.blk_valid_o   = (state_q == EMIT) || (state_q == PAD);
   assign bus_if.blk_data_o    = (state_q == EMIT) ? pack_q :
                                 (state_q == PAD)  ? PAD_BLK : '0;
   assign bus_if.blk_last_o    = (state_q == PAD) || ((state_q == EMIT) && last_q);
   assign bus_if.blk_is_text_o = bus_if.blk_valid_o && (seg_q == SEG_TEXT);
`ifdef ASCON_BLOCK_BYTE_CNT_EN
   assign blk_bytes_o          = (state_q == EMIT) ? bytes_q : '0;
`endif
   assign last_ad_block_o      = pulse_ad;
   assign last_text_block_o    = pulse_text;
   assign busy_o               = (state_q != IDLE);
   assign done_o               = done_q;

endmodule

// File: tb/tb_ascon_block_feeder.sv
// Directed bench for ascon_block_feeder with RATE_BYTES=8.
module tb_ascon_block_feeder;

   localparam int RB = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic ad_empty = 1'b0;
   logic text_empty = 1'b0;
   logic last_ad, last_text, busy, done;
`ifdef ASCON_BLOCK_BYTE_CNT_EN
   logic [3:0] blk_bytes;
`endif

   always #5 clk = ~clk;

   ascon_block_feeder_if #(.RATE_BYTES(RB)) bus ();

   ascon_block_feeder #(.RATE_BYTES(RB)) dut (
      .clk_i             (clk),
      .rst_n_i           (rst_n),
      .start_i           (start),
      .ad_empty_i        (ad_empty),
      .text_empty_i      (text_empty),
      .bus_if            (bus),
`ifdef ASCON_BLOCK_BYTE_CNT_EN
      .blk_bytes_o       (blk_bytes),
`endif
      .last_ad_block_o   (last_ad),
      .last_text_block_o (last_text),
      .busy_o            (busy),
      .done_o            (done)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic             ad_empty;
      logic             text_empty;
      int               n_ad;
      logic [1:0][31:0] ad;
      logic [2:0]       ad_bytes;
      int               n_tx;
      logic [1:0][31:0] tx;
      logic [2:0]       tx_bytes;
      int               n_blk;
      logic [3:0][63:0] exp_data;
      logic [3:0]       exp_text;
      logic [3:0]       exp_last;
      logic [3:0][3:0]  exp_bytes;
   } vec_t;

   vec_t vecs[6];

   task automatic set_vec(input int i, input logic ae, input logic te,
                          input int nad, input logic [31:0] a0, input logic [31:0] a1, input logic [2:0] ab,
                          input int ntx, input logic [31:0] t0, input logic [31:0] t1, input logic [2:0] tb);
      vecs[i].ad_empty = ae;   vecs[i].text_empty = te;
      vecs[i].n_ad = nad;      vecs[i].ad[0] = a0; vecs[i].ad[1] = a1; vecs[i].ad_bytes = ab;
      vecs[i].n_tx = ntx;      vecs[i].tx[0] = t0; vecs[i].tx[1] = t1; vecs[i].tx_bytes = tb;
      vecs[i].n_blk = 0;
   endtask

   task automatic add_blk(input int i, input logic [63:0] d, input logic t, input logic l, input logic [3:0] b);
      vecs[i].exp_data[vecs[i].n_blk]  = d;
      vecs[i].exp_text[vecs[i].n_blk]  = t;
      vecs[i].exp_last[vecs[i].n_blk]  = l;
      vecs[i].exp_bytes[vecs[i].n_blk] = b;
      vecs[i].n_blk++;
   endtask

   task automatic idle_inputs();
      bus.in_valid_i  = 1'b0;
      bus.in_data_i   = '0;
      bus.in_last_i   = 1'b0;
      bus.in_bytes_i  = 3'd0;
      bus.blk_ready_i = 1'b0;
   endtask

   // Non-last words carry in_bytes=1 to confirm the field is ignored there.
   task automatic run_vec(input int vi);
      vec_t        v;
      logic [31:0] wd[4];
      logic        wl[4];
      logic [2:0]  wb[4];
      int          nw, k, wi, n_ad_p, n_tx_p;
      logic        acc, prev_tx, got_done;
      v  = vecs[vi];
      nw = 0;
      for (int i = 0; i < v.n_ad; i++) begin
         wd[nw] = v.ad[i]; wl[nw] = (i == v.n_ad - 1); wb[nw] = wl[nw] ? v.ad_bytes : 3'd1; nw++;
      end
      for (int i = 0; i < v.n_tx; i++) begin
         wd[nw] = v.tx[i]; wl[nw] = (i == v.n_tx - 1); wb[nw] = wl[nw] ? v.tx_bytes : 3'd1; nw++;
      end
      @(negedge clk);
      start = 1'b1; ad_empty = v.ad_empty; text_empty = v.text_empty;
      bus.blk_ready_i = 1'b1;
      k = 0; wi = 0; n_ad_p = 0; n_tx_p = 0; acc = 1'b0; prev_tx = 1'b0; got_done = 1'b0;
      for (int cyc = 0; cyc < 100 && !got_done; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         if (acc) wi++;
         if (bus.blk_valid_o) begin
            if (k < v.n_blk) begin
               check($sformatf("v%0d_blk%0d_data", vi, k), bus.blk_data_o, v.exp_data[k]);
               check($sformatf("v%0d_blk%0d_is_text", vi, k), 64'(bus.blk_is_text_o), 64'(v.exp_text[k]));
               check($sformatf("v%0d_blk%0d_last", vi, k), 64'(bus.blk_last_o), 64'(v.exp_last[k]));
`ifdef ASCON_BLOCK_BYTE_CNT_EN
               check($sformatf("v%0d_blk%0d_bytes", vi, k), 64'(blk_bytes), 64'(v.exp_bytes[k]));
`endif
            end else begin
               check($sformatf("v%0d_extra_block", vi), 64'(k), 64'(v.n_blk - 1));
            end
            k++;
         end
         if (last_ad)   n_ad_p++;
         if (last_text) n_tx_p++;
         if (done) begin
            check($sformatf("v%0d_done_after_last_text", vi), 64'(prev_tx), 64'd1);
            got_done = 1'b1;
         end
         prev_tx = last_text;
         if (wi < nw) begin
            bus.in_valid_i = 1'b1; bus.in_data_i = wd[wi]; bus.in_last_i = wl[wi]; bus.in_bytes_i = wb[wi];
         end else begin
            bus.in_valid_i = 1'b0; bus.in_last_i = 1'b0;
         end
         acc = bus.in_valid_i && bus.in_ready_o;
      end
      check($sformatf("v%0d_done_seen", vi), 64'(got_done), 64'd1);
      check($sformatf("v%0d_block_count", vi), 64'(k), 64'(v.n_blk));
      check($sformatf("v%0d_last_ad_pulses", vi), 64'(n_ad_p), v.ad_empty ? 64'd0 : 64'd1);
      check($sformatf("v%0d_last_text_pulses", vi), 64'(n_tx_p), 64'd1);
      check($sformatf("v%0d_busy_end", vi), 64'(busy), 64'd0);
      $display("[TB] vector %0d: %0d blocks, %0d words", vi, k, wi);
      idle_inputs();
   endtask

   task automatic start_and_emit(input logic te, output logic seen);
      @(negedge clk);
      start = 1'b1; ad_empty = 1'b0; text_empty = te; bus.blk_ready_i = 1'b0;
      @(negedge clk);
      start = 1'b0;
      bus.in_valid_i = 1'b1; bus.in_data_i = 32'h01020304; bus.in_last_i = 1'b1; bus.in_bytes_i = 3'd3;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         bus.in_valid_i = 1'b0; bus.in_last_i = 1'b0;
         seen = bus.blk_valid_o;
      end
      check("emit_reached", 64'(seen), 64'd1);
   endtask

   initial begin
      logic seen;
      set_vec(0, 0, 1, 1, 32'h01020304, 32'h0, 3'd3, 0, 32'h0, 32'h0, 3'd0);
      add_blk(0, 64'h0102038000000000, 0, 1, 4'd3);
      add_blk(0, 64'h8000000000000000, 1, 1, 4'd0);
      set_vec(1, 0, 1, 2, 32'h11111111, 32'h22222222, 3'd4, 0, 32'h0, 32'h0, 3'd0);
      add_blk(1, 64'h1111111122222222, 0, 0, 4'd8);
      add_blk(1, 64'h8000000000000000, 0, 1, 4'd0);
      add_blk(1, 64'h8000000000000000, 1, 1, 4'd0);
      set_vec(2, 1, 0, 0, 32'h0, 32'h0, 3'd0, 1, 32'hAABBCCDD, 32'h0, 3'd2);
      add_blk(2, 64'hAABB800000000000, 1, 1, 4'd2);
      set_vec(3, 1, 1, 0, 32'h0, 32'h0, 3'd0, 0, 32'h0, 32'h0, 3'd0);
      add_blk(3, 64'h8000000000000000, 1, 1, 4'd0);
      set_vec(4, 0, 0, 1, 32'hDEADBEEF, 32'h0, 3'd1, 2, 32'h01234567, 32'h89ABCDEF, 3'd4);
      add_blk(4, 64'hDE80000000000000, 0, 1, 4'd1);
      add_blk(4, 64'h0123456789ABCDEF, 1, 0, 4'd8);
      add_blk(4, 64'h8000000000000000, 1, 1, 4'd0);
      set_vec(5, 0, 0, 1, 32'hCAFEF00D, 32'h0, 3'd4, 2, 32'h11223344, 32'h556677FF, 3'd3);
      add_blk(5, 64'hCAFEF00D80000000, 0, 1, 4'd4);
      add_blk(5, 64'h1122334455667780, 1, 1, 4'd7);

      idle_inputs();
      repeat (3) @(negedge clk);
      check("rst_blk_valid", 64'(bus.blk_valid_o), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready_o), 64'd0);
      check("rst_blk_data", bus.blk_data_o, 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_pulses", {62'd0, last_ad, last_text}, 64'd0);
      rst_n = 1'b1;
      $display("[TB] reset released");

      for (int i = 0; i < 6; i++) run_vec(i);

      // Backpressure on the first AD block, with an ignored start mid-hold.
      start_and_emit(1'b1, seen);
      for (int c = 0; c < 5; c++) begin
         check($sformatf("bp%0d_data", c), bus.blk_data_o, 64'h0102038000000000);
         check($sformatf("bp%0d_valid", c), 64'(bus.blk_valid_o), 64'd1);
         check($sformatf("bp%0d_in_ready", c), 64'(bus.in_ready_o), 64'd0);
         check($sformatf("bp%0d_last_ad", c), 64'(last_ad), 64'd0);
         start = (c == 2);
         @(negedge clk);
      end
      start = 1'b0;
      check("bp_busy", 64'(busy), 64'd1);
      check("bp_data_after_start", bus.blk_data_o, 64'h0102038000000000);
      bus.blk_ready_i = 1'b1;
      #1 check("bp_last_ad_on_ready", 64'(last_ad), 64'd1);
      @(negedge clk);
      bus.blk_ready_i = 1'b0;
      #1;
      check("bp_last_ad_after", 64'(last_ad), 64'd0);
      check("bp_pad_data", bus.blk_data_o, 64'h8000000000000000);
      check("bp_pad_is_text", 64'(bus.blk_is_text_o), 64'd1);
      check("bp_pad_last", 64'(bus.blk_last_o), 64'd1);
      bus.blk_ready_i = 1'b1;
      #1 check("bp_last_text", 64'(last_text), 64'd1);
      @(negedge clk);
      bus.blk_ready_i = 1'b0;
      check("bp_done", 64'(done), 64'd1);
      check("bp_idle", 64'(busy), 64'd0);
      @(negedge clk);
      check("bp_done_one_cycle", 64'(done), 64'd0);
      $display("[TB] backpressure sequence complete");

      // Asynchronous reset while a block is held.
      start_and_emit(1'b0, seen);
      #1 rst_n = 1'b0;
      #1;
      check("arst_blk_valid", 64'(bus.blk_valid_o), 64'd0);
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_pulses", {62'd0, last_ad, last_text}, 64'd0);
      @(negedge clk);
      check("arst_done", 64'(done), 64'd0);
      rst_n = 1'b1;
      $display("[TB] reset-in-EMIT sequence complete");
      run_vec(4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ascon_block_feeder.md
Name: ascon_block_feeder

Overview:
- Writer-side companion of the ASCON core's last-block flag logic.
- Accepts AD and text as a 32-bit word stream, packs it into rate-sized blocks and applies ASCON 10* padding.
- Emits blocks over a valid/ready interface, with last-AD / last-text pulses that the core's flag logic consumes.
- Sits between the bus-side input FIFO and the ASCON permutation datapath.

Parameters:
RATE_BYTES  8  rate in bytes; legal values 8 (ASCON-128) and 16 (ASCON-128a)

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset, asynchronous, active-low
start_i  in  1  start message; sampled only in IDLE
ad_empty_i  in  1  no AD for this message; sampled with start_i
text_empty_i  in  1  no text for this message; sampled with start_i
in_valid_i  in  1  input word valid
in_ready_o  out  1  input word accepted when in_valid_i & in_ready_o
in_data_i  in  32  input word; first byte in [31:24]
in_last_i  in  1  last word of current segment (AD or text)
in_bytes_i  in  3  valid bytes in word, 1..4, left-aligned; meaningful only with in_last_i
blk_valid_o  out  1  block valid
blk_ready_i  in  1  block accepted when blk_valid_o & blk_ready_i
blk_data_o  out  RATE_BYTES*8  padded block; first byte in MSB
blk_is_text_o  out  1  block belongs to text segment; stable while blk_valid_o
blk_last_o  out  1  block is last of its segment; level, qualified by blk_valid_o
last_ad_block_o  out  1  one-cycle pulse on handshake of last AD block
last_text_block_o  out  1  one-cycle pulse on handshake of last text block
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle pulse, cycle after last text block handshake

Behaviour:
- Reset: all outputs 0; state IDLE; byte count 0; pack register 0.
- States:
  - IDLE
  - COLLECT: packing words into the block
  - EMIT: block held, awaiting handshake
  - PAD: pad-only block held
- IDLE + start_i: latch empty flags; segment := AD unless ad_empty_i, then TEXT. Next state COLLECT.
  - Exception: if segment is TEXT and text_empty_i, next state PAD with segment TEXT.
- start_i while busy_o=1 is ignored.
- COLLECT: in_ready_o=1. Each accepted word is written at byte offset cnt; cnt += 4, or += in_bytes_i on the last word.
  - Non-last words are always treated as 4 bytes, whatever in_bytes_i says.
  - Words never straddle blocks, because RATE_BYTES is a multiple of 4.
- Block completion, applied on the accepting cycle; the block is registered, so blk_valid_o rises the next cycle:
  - cnt reaches RATE_BYTES without in_last_i: EMIT, blk_last_o=0.
  - in_last_i and cnt+bytes < RATE_BYTES: byte[cnt+bytes]=0x80, following bytes 0x00; EMIT, blk_last_o=1.
  - in_last_i and cnt+bytes == RATE_BYTES: EMIT full block with blk_last_o=0, then PAD.
- PAD: block = 0x80 followed by zeros; blk_last_o=1.
- EMIT/PAD handshake actions:
  - Clear cnt.
  - Non-last block: return to COLLECT.
  - Last AD block: last_ad_block_o pulses in the handshake cycle. Next state is COLLECT with segment TEXT, or PAD with segment TEXT if text_empty latched.
  - Last text block: last_text_block_o pulses in the handshake cycle; next state IDLE; done_o pulses the following cycle.
- in_ready_o=0 in EMIT, PAD and IDLE; there is no overlap of pack and emit.
- Under backpressure blk_data_o, blk_is_text_o and blk_last_o stay stable.
- Empty AD: no AD block is emitted and last_ad_block_o never pulses.
- Empty text: exactly one pad-only text block is emitted.
- Reset mid-operation aborts the message immediately; no pulses are emitted.

Optional Feature:
- ASCON_BLOCK_BYTE_CNT_EN defined:
  - Adds output blk_bytes_o, width $clog2(RATE_BYTES+1): count of message bytes (excluding pad) in the current block, 0..RATE_BYTES.
  - Used for ciphertext truncation.
  - Value 0 for pad-only blocks.
- Undefined: port and counter register absent; all other behaviour identical.

Decomposition:
- Package ascon_cfg gains:
  - feeder_state_e (IDLE, COLLECT, EMIT, PAD)
  - seg_e (SEG_AD, SEG_TEXT)
  - localparam PAD_BYTE = 8'h80
  - default RATE_BYTES
- One combinational sub-module, ascon_pad_gen:
  - inputs: byte offset, data block
  - outputs: block with 0x80 inserted at the offset and trailing bytes zeroed

Test Plan:
1. RATE_BYTES=8; start, AD word 0x01020304 last bytes=3 → block 0x0102038000000000, is_text=0, last_ad_block_o pulse on handshake.
2. AD words 0x11111111, 0x22222222 (last, bytes=4) → block 0x1111111122222222 with blk_last_o=0, then 0x8000000000000000 with last_ad pulse.
3. text_empty_i=1 after one AD block → text block 0x8000000000000000, last_text_block_o pulse, done_o the next cycle. With ASCON_BLOCK_BYTE_CNT_EN: blk_bytes_o=0.
4. ad_empty_i=1, text word 0xAABBCCDD last bytes=2 → first block 0xAABB800000000000 with is_text=1; last_ad_block_o never pulses.
5. Hold blk_ready_i=0 for 5 cycles on the block from scenario 1 → blk_data_o stable, in_ready_o=0, exactly one last_ad pulse, in the ready cycle.
6. Assert rst_n_i low while in EMIT → blk_valid_o=0 and busy_o=0 immediately; a subsequent start_i runs a clean message.
